// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette playback generator.
// State enum, default half-periods and the bit-to-reload helper.
package cas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } cas_state_t;

  // Half-periods for a 57.272 MHz clock.
  localparam int unsigned HALF_0_DEF = 23863;
  localparam int unsigned HALF_1_DEF = 11932;
  localparam int unsigned CNT_W_DEF  = 16;

  function automatic int unsigned half_period(
    input logic        b,
    input int unsigned h0,
    input int unsigned h1
  );
    return b ? h1 : h0;
  endfunction

endpackage

// File: rtl/cas_if.sv
// Byte-stream handshake into the cassette player.
// master: byte source; slave: cas_player.
interface cas_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/cas_half_timer.sv
// Loadable half-period down-counter with enable.
// Ports: clk, reset, load/load_val, en; done strobes while count==1.
module cas_half_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/cas_player.sv
// Cassette FSK playback: bytes in, LSB-first 1200/2400 Hz square wave out.
// Ports: clk, reset, motor, bus (byte handshake), casdout, busy, underrun, bytes_sent.
module cas_player
  import cas_pkg::*;
#(
  parameter int unsigned HALF_0 = HALF_0_DEF,
  parameter int unsigned HALF_1 = HALF_1_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor,
  cas_if.slave        bus,
  output logic        casdout,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] bytes_sent
);

  cas_state_t state, state_n;

  logic [7:0]  hold;
  logic        hold_full;
  logic [7:0]  shr;
  logic [2:0]  idx;
  logic [15:0] sent_q;
  logic        underrun_q;

  logic             xfer;
  logic             ld_byte;
  logic             shift;
  logic             byte_done;
  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_done;

  assign bus.byte_ready = ~hold_full;
  assign xfer = bus.byte_valid & ~hold_full;

  cas_half_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .en       (motor),
    .done     (t_done)
  );

  always_comb begin
    state_n   = state;
    ld_byte   = 1'b0;
    shift     = 1'b0;
    byte_done = 1'b0;
    t_load    = 1'b0;
    t_val     = '0;
    unique case (state)
      IDLE: begin
        if (motor && hold_full) begin
          ld_byte = 1'b1;
          t_load  = 1'b1;
          t_val   = CNT_W'(half_period(hold[0], HALF_0, HALF_1));
          state_n = HI;
        end
      end
      HI: begin
        if (motor && t_done) begin
          t_load  = 1'b1;
          t_val   = CNT_W'(half_period(shr[0], HALF_0, HALF_1));
          state_n = LO;
        end
      end
      LO: begin
        if (motor && t_done) begin
          if (idx != 3'd7) begin
            shift   = 1'b1;
            t_load  = 1'b1;
            t_val   = CNT_W'(half_period(shr[1], HALF_0, HALF_1));
            state_n = HI;
          end else begin
            byte_done = 1'b1;
            // Chain straight into the held byte so there is no gap.
            if (hold_full) begin
              ld_byte = 1'b1;
              t_load  = 1'b1;
              t_val   = CNT_W'(half_period(hold[0], HALF_0, HALF_1));
              state_n = HI;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shr        <= '0;
      idx        <= '0;
      sent_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state      <= state_n;
      underrun_q <= byte_done & ~ld_byte;
      if (byte_done) sent_q <= sent_q + 16'd1;
      if (xfer) hold <= bus.byte_data;
      hold_full <= (hold_full & ~ld_byte) | xfer;
      if (ld_byte) begin
        shr <= hold;
        idx <= '0;
      end else if (shift) begin
        shr <= shr >> 1;
        idx <= idx + 3'd1;
      end
    end
  end

  // Level is gated by the relay so a stopped tape reads low.
  assign casdout    = (state == HI) & motor;
  assign busy       = (state == HI) | (state == LO);
  assign underrun   = underrun_q;
  assign bytes_sent = sent_q;

endmodule

// File: tb/tb_cas_player.sv
// Self-checking bench for cas_player with HALF_0=8, HALF_1=4.
// Waveforms are checked against an expected sample stream built from the bytes.
module tb_cas_player;
  localparam int H0 = 8;
  localparam int H1 = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        motor = 1'b0;
  logic        casdout;
  logic        busy;
  logic        underrun;
  logic [15:0] bytes_sent;

  cas_if bus ();

  cas_player #(
    .HALF_0 (H0),
    .HALF_1 (H1),
    .CNT_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .motor      (motor),
    .bus        (bus),
    .casdout    (casdout),
    .busy       (busy),
    .underrun   (underrun),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit   rec = 1'b0;
  bit   wave[$];
  int   und_cnt = 0;

  always @(negedge clk) begin
    if (rec) begin
      wave.push_back(casdout);
      if (underrun) und_cnt++;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_rec();
    wave.delete();
    und_cnt = 0;
    rec = 1'b1;
  endtask

  function automatic int half_of(input bit b);
    return b ? H1 : H0;
  endfunction

  // Bit i of a byte is half(b) high samples then half(b) low samples.
  function automatic void build(input byte unsigned bs[$], output bit exp[$]);
    exp.delete();
    foreach (bs[j]) begin
      for (int i = 0; i < 8; i++) begin
        int h;
        h = half_of(bs[j][i]);
        for (int k = 0; k < h; k++) exp.push_back(1'b1);
        for (int k = 0; k < h; k++) exp.push_back(1'b0);
      end
    end
  endfunction

  function automatic int first_one();
    foreach (wave[i]) if (wave[i]) return i;
    return -1;
  endfunction

  task automatic cmp_wave(input string tag, input bit exp[$]);
    int f;
    int errs;
    f = first_one();
    errs = 0;
    if (f < 0) begin
      errs = 1;
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        if (f + i >= wave.size()) errs++;
        else if (wave[f+i] != exp[i]) errs++;
      end
      for (int i = f + exp.size(); i < wave.size(); i++)
        if (wave[i]) errs++;
    end
    check(tag, errs, 0);
  endtask

  task automatic push(input byte unsigned d);
    int n;
    bus.byte_data  = d;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("push_timeout", 1, 0);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check({tag, "_start_timeout"}, 1, 0);
    n = 0;
    while (!(!busy && bus.byte_ready) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check({tag, "_end_timeout"}, 1, 0);
    repeat (4) tick();
  endtask

  task automatic wait_rise(input string tag);
    int n;
    n = 0;
    while (!casdout && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check({tag, "_rise_timeout"}, 1, 0);
  endtask

  function automatic int cycles_before(input byte unsigned d, input int nb);
    int s;
    s = 0;
    for (int i = 0; i < nb; i++) s += 2 * half_of(d[i]);
    return s;
  endfunction

  initial begin
    byte unsigned bs[$];
    bit           exp[$];
    byte unsigned d;
    int           k;
    int           base;
    int           ones;

    bus.byte_data  = '0;
    bus.byte_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_casdout", casdout, 0);
    check("rst_ready", bus.byte_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_sent", bytes_sent, 0);

    // Single byte 0xA5.
    motor = 1'b1;
    start_rec();
    push(8'hA5);
    wait_idle("a5");
    bs = '{8'hA5};
    build(bs, exp);
    cmp_wave("a5_wave", exp);
    check("a5_sent", bytes_sent, 1);
    check("a5_underrun", und_cnt, 1);
    check("a5_idle_level", casdout, 0);

    // 0x00 then 0xFF back to back.
    start_rec();
    push(8'h00);
    push(8'hFF);
    wait_idle("b2b");
    bs = '{8'h00, 8'hFF};
    build(bs, exp);
    check("b2b_len", exp.size(), 192);
    cmp_wave("b2b_wave", exp);
    check("b2b_underrun", und_cnt, 1);
    check("b2b_sent", bytes_sent, 3);

    // Preload with motor off, then raise the motor.
    motor = 1'b0;
    start_rec();
    push(8'h3C);
    repeat (10) tick();
    check("pre_ready", bus.byte_ready, 0);
    check("pre_busy", busy, 0);
    ones = 0;
    foreach (wave[i]) if (wave[i]) ones++;
    check("pre_quiet", ones, 0);
    motor = 1'b1;
    start_rec();
    wait_idle("pre");
    check("pre_first_rise", first_one(), 1);
    bs = '{8'h3C};
    build(bs, exp);
    cmp_wave("pre_wave", exp);

    // Freeze 20 cycles inside the HI half of bit 3.
    d = 8'($urandom_range(255));
    start_rec();
    push(d);
    wait_rise("frz");
    k = cycles_before(d, 3) + 2;
    repeat (k) tick();
    motor = 1'b0;
    tick();
    check("frz_level", casdout, 0);
    check("frz_busy", busy, 1);
    repeat (19) tick();
    motor = 1'b1;
    wait_idle("frz");
    bs = '{d};
    build(bs, exp);
    for (int i = 0; i < 20; i++) exp.insert(k, 1'b0);
    cmp_wave("frz_wave", exp);
    check("frz_underrun", und_cnt, 1);

    // Reset in the middle of bit 5.
    d = 8'($urandom_range(255));
    push(d);
    wait_rise("rst");
    repeat (cycles_before(d, 5) + 3) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_casdout", casdout, 0);
    check("mid_rst_ready", bus.byte_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sent", bytes_sent, 0);
    reset = 1'b0;
    d = 8'($urandom_range(255));
    start_rec();
    push(d);
    wait_idle("post_rst");
    bs = '{d};
    build(bs, exp);
    cmp_wave("post_rst_wave", exp);
    check("post_rst_sent", bytes_sent, 1);

    // Random back-to-back bursts.
    for (int r = 0; r < 3; r++) begin
      bs.delete();
      for (int j = 0; j < 2 + r; j++) bs.push_back(8'($urandom_range(255)));
      base = int'(bytes_sent);
      start_rec();
      foreach (bs[j]) push(bs[j]);
      wait_idle("rnd");
      build(bs, exp);
      cmp_wave($sformatf("rnd%0d_wave", r), exp);
      check($sformatf("rnd%0d_sent", r), bytes_sent, base + bs.size());
      check($sformatf("rnd%0d_underrun", r), und_cnt, 1);
    end

    // Counter wrap from 0xFFFF.
    force dut.sent_q = 16'hFFFF;
    tick();
    release dut.sent_q;
    tick();
    check("wrap_pre", bytes_sent, 16'hFFFF);
    push(8'($urandom_range(255)));
    wait_idle("wrap");
    check("wrap_post", bytes_sent, 0);

    rec = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
